// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator.
// Raster counters (hc/vc) advance under en; restart returns them to (0,0).
// Sync, active-video, coordinates and line/frame/vblank strobes are decoded
// from the current counters and registered together. All outputs share one
// cycle of latency relative to the counters.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 128,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 9,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 28,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CNT_W      = 10
) (
  input  logic             px_clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             restart,
  output logic             hsync,
  output logic             vsync,
  output logic             activevideo,
  output logic [CNT_W-1:0] x_px,
  output logic [CNT_W-1:0] y_px,
  output logic             line_start,
  output logic             frame_start,
  output logic             vblank_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Decode boundaries, all unsigned in CNT_W bits.
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] hc_p0;
  logic [CNT_W-1:0] vc_p0;
  logic             act_p0;
  logic             hs_on_p0;
  logic             vs_on_p0;
  logic             step_p0;
  logic             hc_zero_p0;

  // Stage p0: raster counters; restart wins over en, line/frame wrap under en.
  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_p0 <= CNT_ZERO;
      vc_p0 <= CNT_ZERO;
    end else if (restart) begin
      hc_p0 <= CNT_ZERO;
      vc_p0 <= CNT_ZERO;
    end else if (en) begin
      if (hc_p0 == H_LAST) begin
        hc_p0 <= CNT_ZERO;
        if (vc_p0 == V_LAST) begin
          vc_p0 <= CNT_ZERO;
        end else begin
          vc_p0 <= vc_p0 + CNT_ONE;
        end
      end else begin
        hc_p0 <= hc_p0 + CNT_ONE;
      end
    end
  end

  // Combinational decode of the current raster position.
  always_comb begin
    act_p0     = (hc_p0 < H_ACT) && (vc_p0 < V_ACT);
    hs_on_p0   = (hc_p0 >= HS_BEG) && (hc_p0 < HS_END);
    vs_on_p0   = (vc_p0 >= VS_BEG) && (vc_p0 < VS_END);
    step_p0    = en && !restart;
    hc_zero_p0 = (hc_p0 == CNT_ZERO);
  end

  // Stage p1: registered outputs; pixel fields hold while paused, strobes
  // are suppressed on paused or restarting cycles so each event pulses once.
  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_px         <= CNT_ZERO;
      y_px         <= CNT_ZERO;
      activevideo  <= 1'b0;
      hsync        <= ~H_SYNC_POL;
      vsync        <= ~V_SYNC_POL;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      if (en) begin
        x_px        <= hc_p0;
        y_px        <= vc_p0;
        activevideo <= act_p0;
        hsync       <= hs_on_p0 ? H_SYNC_POL : ~H_SYNC_POL;
        vsync       <= vs_on_p0 ? V_SYNC_POL : ~V_SYNC_POL;
      end
      line_start   <= step_p0 && hc_zero_p0;
      frame_start  <= step_p0 && hc_zero_p0 && (vc_p0 == CNT_ZERO);
      vblank_start <= step_p0 && hc_zero_p0 && (vc_p0 == V_ACT);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in a small raster mode (28x13 total) with mixed
// sync polarities. A linear pixel-index model predicts every output.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 3, HS = 4, HB = 5;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;   // 28
  localparam int VT = VA + VF + VS + VB;   // 13
  localparam int FR = HT * VT;             // 364
  localparam int CW = 5;

  logic          px_clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic          restart;
  logic          hsync, vsync, activevideo;
  logic [CW-1:0] x_px, y_px;
  logic          line_start, frame_start, vblank_start;

  int tests = 0;
  int fails = 0;
  logic chk_on = 1'b0;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .CNT_W(CW)
  ) dut (
    .px_clk(px_clk), .reset_n(reset_n), .en(en), .restart(restart),
    .hsync(hsync), .vsync(vsync), .activevideo(activevideo),
    .x_px(x_px), .y_px(y_px),
    .line_start(line_start), .frame_start(frame_start),
    .vblank_start(vblank_start)
  );

  always #5 px_clk = ~px_clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event not seen within cycle budget (t=%0t)", name, $time);
  endtask

  // Reference model: a single pixel index within the frame; x/y by div/mod.
  int   pos;
  int   ex, ey;
  logic eav, ehs, evs, els, efs, evb;

  always @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      pos <= 0; ex <= 0; ey <= 0; eav <= 1'b0;
      ehs <= 1'b0; evs <= 1'b1;
      els <= 1'b0; efs <= 1'b0; evb <= 1'b0;
    end else begin
      if (en) begin
        ex  <= pos % HT;
        ey  <= pos / HT;
        eav <= ((pos % HT) < HA) && ((pos / HT) < VA);
        ehs <= ((pos % HT) >= HA + HF) && ((pos % HT) < HA + HF + HS);
        evs <= !(((pos / HT) >= VA + VF) && ((pos / HT) < VA + VF + VS));
      end
      els <= en && !restart && (pos % HT == 0);
      efs <= en && !restart && (pos == 0);
      evb <= en && !restart && (pos == VA * HT);
      if (restart)  pos <= 0;
      else if (en)  pos <= (pos + 1) % FR;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge px_clk) begin
    if (chk_on) begin
      check("x_px", int'(x_px), ex);
      check("y_px", int'(y_px), ey);
      check("activevideo", int'(activevideo), int'(eav));
      check("hsync", int'(hsync), int'(ehs));
      check("vsync", int'(vsync), int'(evs));
      check("line_start", int'(line_start), int'(els));
      check("frame_start", int'(frame_start), int'(efs));
      check("vblank_start", int'(vblank_start), int'(evb));
    end
  end

  initial begin
    int n_av, n_hs, n_vs, n_ls, n_vb, hs_x, vs_y, vb_y, k;
    bit found;

    reset_n = 1'b0; en = 1'b0; restart = 1'b0;
    repeat (3) @(negedge px_clk);
    check("rst_x", int'(x_px), 0);
    check("rst_av", int'(activevideo), 0);
    check("rst_hsync", int'(hsync), 0);
    check("rst_vsync", int'(vsync), 1);
    check("rst_fs", int'(frame_start), 0);

    // First edge after release.
    reset_n = 1'b1; en = 1'b1; chk_on = 1'b1;
    @(posedge px_clk); #1;
    check("first_x", int'(x_px), 0);
    check("first_y", int'(y_px), 0);
    check("first_av", int'(activevideo), 1);
    check("first_ls", int'(line_start), 1);
    check("first_fs", int'(frame_start), 1);

    // Randomised enable / restart traffic.
    repeat (3000) begin
      @(negedge px_clk);
      en      = ($urandom_range(0, 9) != 0);
      restart = ($urandom_range(0, 199) == 0);
    end

    // Full-frame statistics with en held high.
    @(negedge px_clk); en = 1'b1; restart = 1'b0;
    found = 0;
    for (int i = 0; i < 2 * FR + 4 && !found; i++) begin
      @(negedge px_clk);
      if (frame_start) found = 1;
    end
    if (!found) timeout_fail("frame_start_wait");
    n_av = 0; n_hs = 0; n_vs = 0; n_ls = 0; n_vb = 0;
    hs_x = -1; vs_y = -1; vb_y = -1;
    for (k = 0; k < FR; k++) begin
      if (activevideo) n_av++;
      if (hsync) begin n_hs++; if (hs_x < 0) hs_x = int'(x_px); end
      if (!vsync) begin n_vs++; if (vs_y < 0) vs_y = int'(y_px); end
      if (line_start) n_ls++;
      if (vblank_start) begin n_vb++; vb_y = int'(y_px); end
      @(negedge px_clk);
    end
    check("frame_period_fs", int'(frame_start), 1);
    check("active_cycles", n_av, 96);
    check("hsync_cycles", n_hs, 52);
    check("hsync_first_x", hs_x, 19);
    check("vsync_cycles", n_vs, 56);
    check("vsync_first_y", vs_y, 8);
    check("line_starts", n_ls, 13);
    check("vblank_starts", n_vb, 1);
    check("vblank_y", vb_y, 6);

    // Pause at x_px==10 for 20 cycles.
    found = 0;
    for (int i = 0; i < 2 * HT && !found; i++) begin
      if (int'(x_px) == 10) found = 1;
      else @(negedge px_clk);
    end
    if (!found) timeout_fail("pause_x_wait");
    en = 1'b0;
    repeat (20) @(negedge px_clk);
    check("pause_hold_x", int'(x_px), 10);
    check("pause_ls", int'(line_start), 0);
    en = 1'b1;
    @(negedge px_clk);
    check("pause_resume_x", int'(x_px), 11);

    // Restart with en low during the restart cycle.
    repeat (40) @(negedge px_clk);
    restart = 1'b1; en = 1'b0;
    @(negedge px_clk);
    restart = 1'b0; en = 1'b1;
    @(negedge px_clk);
    check("rs0_x", int'(x_px), 0);
    check("rs0_y", int'(y_px), 0);
    check("rs0_fs", int'(frame_start), 1);

    // Restart with en high.
    repeat (70) @(negedge px_clk);
    restart = 1'b1;
    @(negedge px_clk);
    restart = 1'b0;
    @(negedge px_clk);
    check("rs1_x", int'(x_px), 0);
    check("rs1_y", int'(y_px), 0);
    check("rs1_fs", int'(frame_start), 1);

    // Asynchronous reset mid-line.
    repeat (33) @(negedge px_clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_x", int'(x_px), 0);
    check("arst_y", int'(y_px), 0);
    check("arst_av", int'(activevideo), 0);
    check("arst_hsync", int'(hsync), 0);
    check("arst_vsync", int'(vsync), 1);
    @(negedge px_clk);
    reset_n = 1'b1;
    @(posedge px_clk); #1;
    check("arst_first_x", int'(x_px), 0);
    check("arst_first_av", int'(activevideo), 1);
    check("arst_first_fs", int'(frame_start), 1);

    repeat (500) begin
      @(negedge px_clk);
      en      = ($urandom_range(0, 3) != 0);
      restart = ($urandom_range(0, 99) == 0);
    end
    @(negedge px_clk);
    chk_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator: the successor to the fixed 640x480@72Hz sync generator. It produces hsync, vsync, active-video and pixel coordinates for any mode set by parameters, with per-axis sync polarity and a pixel-clock enable for pause. It also provides a synchronous restart and line/frame/vblank strobes that drive the cell-update engine and the framebuffer readout. It sits between the pixel clock domain root and the pixel pipeline. All outputs are registered and mutually aligned.

## Interface

- H_ACTIVE, 640, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 40, hsync pulse width (pixels)
- H_BP, 128, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 9, vertical front porch (lines)
- V_SYNC, 3, vsync pulse width (lines)
- V_BP, 28, vertical back porch (lines)
- H_SYNC_POL, 0, asserted level of hsync (0 = active-low)
- V_SYNC_POL, 0, asserted level of vsync
- CNT_W, 10, counter/coordinate width; must satisfy 2^CNT_W > H_TOTAL-1 and V_TOTAL-1
- px_clk  in  1  pixel clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  pixel enable; counters advance only when high
- restart  in  1  synchronous restart to (0,0); priority over en
- hsync  out  1  horizontal sync, polarity per H_SYNC_POL
- vsync  out  1  vertical sync, polarity per V_SYNC_POL
- activevideo  out  1  high while the pixel is inside the visible area
- x_px  out  CNT_W  horizontal counter value (0..H_TOTAL-1)
- y_px  out  CNT_W  vertical counter value (0..V_TOTAL-1)
- line_start  out  1  one-cycle strobe at hc==0
- frame_start  out  1  one-cycle strobe at hc==0 && vc==0
- vblank_start  out  1  one-cycle strobe at hc==0 && vc==V_ACTIVE

## Operation

- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 832); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 520).
- Line order: active, front porch, sync, back porch. Frame order is the same. Coordinate 0 is the first visible pixel.
- Internal counters hc and vc:
  - If restart: hc=0, vc=0.
  - Else if en: if hc==H_TOTAL-1 then hc=0, and vc wraps to 0 at V_TOTAL-1, otherwise increments. Else hc increments.
  - Else: hold.
- Decode from the current hc/vc, then register into the outputs on the same edge:
  - Active: hc<H_ACTIVE && vc<V_ACTIVE.
  - hsync asserted: H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted: V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, for the whole of each of those lines.
  - Deasserted syncs drive the inverse polarity level.
- Strobes are gated: they register as 0 in any cycle where en==0 or restart==1. This guarantees exactly one pulse per event.
- x_px and y_px always carry the raw counters; consumers qualify them with activevideo.
- All arithmetic is unsigned in CNT_W bits. Comparisons use constants computed at elaboration. No wrap occurs within range by construction.

## Timing

- Reset (async assert, sync release internal to the flops):
  - hc=vc=0, x_px=y_px=0.
  - activevideo=0 and all strobes 0.
  - hsync=~H_SYNC_POL, vsync=~V_SYNC_POL (both deasserted).
- Latency: outputs at edge n+1 reflect the counters as they were before edge n+1. x_px, y_px, syncs, activevideo and strobes are cycle-aligned with each other.
- First edge after reset release with en=1: x_px=0, y_px=0, activevideo=1, line_start=1, frame_start=1. The counter is now at hc=1.
- en low: outputs hold their last values except the strobes, which are 0. Resuming continues from the held position with no skipped or repeated pixel.
- restart mid-frame: on the next edge the counters are (0,0). The edge after that shows x_px=0, y_px=0, frame_start=1, even if en was 0 during the restart cycle.
- Simultaneous restart and en: restart wins. The line/frame wrap is not taken.
- Frame period with en tied high: exactly H_TOTAL*V_TOTAL cycles between frame_start pulses (default 432640).

## Test plan

- Reset: assert reset_n=0 mid-line. All outputs go to their reset values immediately, without waiting for a clock. Release; the first edge gives x_px=0, y_px=0, activevideo=1, frame_start=1.
- Default horizontal: observe one line. activevideo is high for 640 cycles. hsync is low for exactly 40 cycles, starting when x_px==664. line_start repeats every 832 cycles.
- Default vertical: run 2 frames. frame_start pulses are 432640 cycles apart. vblank_start fires once per frame, with y_px==480. vsync is low on lines 489-491 (3*832 cycles).
- Pause: drop en for 100 cycles at x_px==300. x_px stays 300, no strobes fire, and the next value after resume is 301. The frame period grows by exactly 100.
- Restart: pulse restart at y_px==200 with en=1. Two edges later, x_px=0, y_px=0 and frame_start=1. Repeat with en=0: the same result.
- Alternate mode: H=800/40/128/88, V=600/1/4/23, both polarities 1, CNT_W=11. hsync is high for 128 cycles from x_px==840. vsync is high on lines 601-604. The frame period is 1056*628 = 663168 cycles.
